// File: rtl/radix_4_ntt_stage_input_buffer.sv
// Input buffer for one radix-4 NTT stage: collects a block of 4*L coefficients in
// natural order, then presents L butterfly groups (x[j], x[j+L], x[j+2L], x[j+3L]).
module radix_4_ntt_stage_input_buffer #(
    parameter int N     = 17,
    parameter int LOG_L = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N-1:0]                          in_data,
    input  logic                                  in_inv,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N-1:0]                          out_a0,
    output logic [N-1:0]                          out_a1,
    output logic [N-1:0]                          out_a2,
    output logic [N-1:0]                          out_a3,
    output logic [((LOG_L > 0) ? LOG_L : 1)-1:0]  out_idx,
    output logic                                  out_inv
);

    localparam int L  = 1 << LOG_L;
    localparam int IW = (LOG_L > 0) ? LOG_L : 1;
    localparam int AW = LOG_L + 2;
    localparam logic [AW-1:0] WR_LAST = AW'(4 * L - 1);
    localparam logic [IW-1:0] RD_LAST = IW'(L - 1);

    // Handshake rule: a word moves on in_valid && in_ready, a group moves on
    // out_valid && out_ready; both ready/valid sides are registered state flags.
    typedef enum logic {FILL, DRAIN} state_t;

    state_t         state_q;
    logic [AW-1:0]  wr_q;
    logic [IW-1:0]  rd_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           out_inv_q;

    // The four banks live in one flat array; bank b holds words b*L .. b*L+L-1.
    logic [N-1:0]   mem [4*L];
    logic [AW-1:0]  rd_addr [4];
    logic           in_hs;
    logic           out_hs;

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (in_hs) begin
            mem[wr_q] <= in_data;
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            rd_addr[b] = (AW'(b) << LOG_L) | AW'(rd_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_q        <= '0;
            rd_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_inv_q   <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_hs) begin
                        if (wr_q == '0) begin
                            out_inv_q <= in_inv;
                        end
                        if (wr_q == WR_LAST) begin
                            wr_q        <= '0;
                            state_q     <= DRAIN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            wr_q <= wr_q + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (rd_q == RD_LAST) begin
                            rd_q        <= '0;
                            state_q     <= FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else begin
                            rd_q <= rd_q + IW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_inv   = out_inv_q;
    assign out_idx   = rd_q;
    assign out_a0    = mem[rd_addr[0]];
    assign out_a1    = mem[rd_addr[1]];
    assign out_a2    = mem[rd_addr[2]];
    assign out_a3    = mem[rd_addr[3]];

endmodule

// File: tb/tb_radix_4_ntt_stage_input_buffer.sv
// Bench for radix_4_ntt_stage_input_buffer: a block-level model predicts every
// butterfly group; a monitor pops and compares on each output handshake.
module tb_radix_4_ntt_stage_input_buffer;

    localparam int N  = 17;
    localparam int LG = 2;
    localparam int L  = 1 << LG;
    localparam int IW = 2;
    localparam int EW = 1 + IW + 4 * N;
    localparam int EW0 = 1 + 1 + 4 * N;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT (LOG_L=2) ----------------
    logic          in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
    logic [N-1:0]  in_data, out_a0, out_a1, out_a2, out_a3;
    logic [IW-1:0] out_idx;

    radix_4_ntt_stage_input_buffer #(.N(N), .LOG_L(LG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a0(out_a0), .out_a1(out_a1), .out_a2(out_a2), .out_a3(out_a3),
        .out_idx(out_idx), .out_inv(out_inv)
    );

    // ---------------- DUT (LOG_L=0) ----------------
    logic          in_valid0, in_ready0, in_inv0, out_valid0, out_ready0, out_inv0;
    logic [N-1:0]  in_data0, out0_a0, out0_a1, out0_a2, out0_a3;
    logic [0:0]    out_idx0;

    radix_4_ntt_stage_input_buffer #(.N(N), .LOG_L(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_inv(in_inv0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_a0(out0_a0), .out_a1(out0_a1), .out_a2(out0_a2), .out_a3(out0_a3),
        .out_idx(out_idx0), .out_inv(out_inv0)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0]  exp_q[$];
    logic [EW0-1:0] exp0_q[$];
    logic [N-1:0]   blk[$];
    logic [N-1:0]   last_blk[$];
    logic           blk_inv;
    logic           fill_chk = 1'b0;
    int             rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by hand
    logic [N-1:0]   tx_d[16];
    logic           tx_i[16];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Reference model: collect the block, then emit groups j = 0..L-1 as
    // (x[j], x[j+L], x[j+2L], x[j+3L]) with the inv flag taken from word 0.
    task automatic model_accept(input logic [N-1:0] d, input logic inv);
        if (blk.size() == 0) blk_inv = inv;
        blk.push_back(d);
        if (blk.size() == 4 * L) begin
            for (int j = 0; j < L; j++)
                exp_q.push_back({blk_inv, IW'(j), blk[j+3*L], blk[j+2*L], blk[j+L], blk[j]});
            last_blk = blk;
            blk.delete();
        end
    endtask

    task automatic model_clear();
        blk.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [N-1:0] d, input logic inv);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 128'(in_ready), 128'(1));
        end else begin
            model_accept(d, inv);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int first, input int count, input int gap_pct);
        for (int i = first; i < first + count; i++) begin
            if (gap_pct > 0) begin
                while ($urandom_range(0, 99) < gap_pct) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_word(tx_d[i], tx_i[i]);
        end
    endtask

    task automatic check_first_out();
        @(negedge clk);
        check("first_out_valid", 128'(out_valid), 128'(1));
        check("drain_in_ready", 128'(in_ready), 128'(0));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- ready generator ----------------
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n) begin
            if (fill_chk) begin
                check("refill_in_ready", 128'(in_ready), 128'(1));
                check("refill_out_valid", 128'(out_valid), 128'(0));
                fill_chk = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_group", 128'(out_idx), 128'({1'b1, 8'h00}));
                end else begin
                    e = exp_q.pop_front();
                    check("group", 128'({out_inv, out_idx, out_a3, out_a2, out_a1, out_a0}), 128'(e));
                    if (e[EW-2 -: IW] == IW'(L - 1)) fill_chk = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [EW0-1:0] e0;
        if (rst_n && out_valid0 && out_ready0) begin
            if (exp0_q.size() == 0) begin
                check("unexpected_group0", 128'(out_idx0), 128'({1'b1, 8'h00}));
            end else begin
                e0 = exp0_q.pop_front();
                check("group_l1", 128'({out_inv0, out_idx0, out0_a3, out0_a2, out0_a1, out0_a0}), 128'(e0));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] v4[4];
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
        in_valid0 = 1'b0; in_data0 = '0; in_inv0 = 1'b0; out_ready0 = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_out_idx", 128'(out_idx), 128'(0));
        check("reset_out_inv", 128'(out_inv), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // natural-order block 0..15, in_valid held, always ready
        for (int i = 0; i < 16; i++) begin tx_d[i] = N'(i); tx_i[i] = 1'b0; end
        send_block(0, 16, 0);
        check_first_out();
        wait_drain();

        // backpressure on group 1
        rdy_mode = 2;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin tx_d[i] = N'($urandom); tx_i[i] = 1'b0; end
        send_block(0, 16, 0);
        check_first_out();
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_idx", 128'(out_idx), 128'(1));
            check("bp_data", 128'({out_a3, out_a2, out_a1, out_a0}),
                  128'({last_blk[13], last_blk[9], last_blk[5], last_blk[1]}));
        end
        @(posedge clk); #1;
        rdy_mode = 0;
        wait_drain();

        // bit-exact maximum value, inv taken only from word 0
        for (int i = 0; i < 16; i++) begin tx_d[i] = 17'd65536; tx_i[i] = (i == 0); end
        send_block(0, 16, 0);
        wait_drain();
        for (int i = 0; i < 16; i++) begin tx_d[i] = N'($urandom); tx_i[i] = (i != 0); end
        send_block(0, 16, 0);
        wait_drain();

        // 50% input gaps, random ready; then junk offered during DRAIN
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) begin tx_d[i] = N'(i); tx_i[i] = 1'b0; end
        send_block(0, 16, 50);
        @(posedge clk); #1;
        rdy_mode = 2; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 17'd999; in_inv = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        rdy_mode = 1;
        wait_drain();
        for (int i = 0; i < 16; i++) begin tx_d[i] = N'($urandom); tx_i[i] = 1'($urandom); end
        send_block(0, 16, 30);
        wait_drain();

        // async reset mid-FILL, then mid-DRAIN, then refill 100..115
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) begin tx_d[i] = N'($urandom); tx_i[i] = 1'b1; end
        send_block(0, 7, 0);
        #2;
        do_reset_pulse();
        rdy_mode = 2; out_ready = 1'b0;
        send_block(0, 16, 0);
        check_first_out();
        #2;
        do_reset_pulse();
        check("rst_out_inv", 128'(out_inv), 128'(0));
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) begin tx_d[i] = N'(100 + i); tx_i[i] = 1'b0; end
        send_block(0, 16, 0);
        wait_drain();

        // random blocks
        rdy_mode = 1;
        repeat (4) begin
            for (int i = 0; i < 16; i++) begin tx_d[i] = N'($urandom); tx_i[i] = 1'($urandom); end
            send_block(0, 16, 50);
            wait_drain();
        end

        // LOG_L=0 instance: one block, one group
        v4[0] = 17'd10; v4[1] = 17'd20; v4[2] = 17'd30; v4[3] = 17'd40;
        exp0_q.push_back({1'b0, 1'b0, v4[3], v4[2], v4[1], v4[0]});
        for (int i = 0; i < 4; i++) begin
            in_valid0 = 1'b1; in_data0 = v4[i]; in_inv0 = 1'b0;
            @(negedge clk);
            check("l1_in_ready", 128'(in_ready0), 128'(1));
            @(posedge clk); #1;
        end
        in_valid0 = 1'b0;
        @(negedge clk);
        check("l1_out_valid", 128'(out_valid0), 128'(1));
        @(negedge clk);
        check("l1_refill_ready", 128'(in_ready0), 128'(1));
        check("l1_refill_valid", 128'(out_valid0), 128'(0));

        check("exp_q_empty", 128'(exp_q.size()), 128'(0));
        check("exp0_q_empty", 128'(exp0_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
